// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// Holds the FSM state encoding and the default parameter values.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam int CNT_W_DEF       = 16;
    localparam int MEM_TIMEOUT_DEF = 64;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Control bundle between the stall sequencer and its pipeline environment.
// slave = the sequencer, master = hazard unit / memory / pipeline side.
interface pipeline_stall_ctrl_if
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             start_i;
    logic             load_use_i;
    logic             branch_taken_i;
    logic             mem_req_i;
    logic             mem_ready_i;
    logic             PCWrite_o;
    logic             IF_ID_Write_o;
    logic             IF_ID_Flush_o;
    logic             ID_EX_NoOp_o;
    logic             EX_MEM_Write_o;
    logic             MEM_WB_NoOp_o;
    logic             mem_wait_o;
    logic             mem_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [CNT_W-1:0] memwait_cnt_o;

    modport master (
        output start_i, load_use_i, branch_taken_i,
        output mem_req_i, mem_ready_i,
        input  PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o,
        input  ID_EX_NoOp_o, EX_MEM_Write_o, MEM_WB_NoOp_o,
        input  mem_wait_o, mem_timeout_o,
        input  stall_cnt_o, flush_cnt_o, memwait_cnt_o
    );

    modport slave (
        input  start_i, load_use_i, branch_taken_i,
        input  mem_req_i, mem_ready_i,
        output PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o,
        output ID_EX_NoOp_o, EX_MEM_Write_o, MEM_WB_NoOp_o,
        output mem_wait_o, mem_timeout_o,
        output stall_cnt_o, flush_cnt_o, memwait_cnt_o
    );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
// Synchronous active-high clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: hold once every bit is set.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: memory wait > load-use > branch flush.
// Drives pipeline-register enables, bubbles, flushes and perf counters.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pipeline_stall_ctrl_if.slave  bus
);

    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

    state_e          state_q;
    state_e          state_d;
    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;
    logic            to_q;
    logic            to_set;

    logic            pc_we;
    logic            ifid_we;
    logic            ifid_fl;
    logic            idex_nop;
    logic            exmem_we;
    logic            memwb_nop;

    logic            stall_inc;
    logic            flush_inc;
    logic            mw_inc;

    // Next state, watchdog and pipeline controls from state and inputs.
    always_comb begin
        state_d   = state_q;
        wd_d      = '0;
        to_set    = 1'b0;
        pc_we     = 1'b0;
        ifid_we   = 1'b0;
        ifid_fl   = 1'b0;
        idex_nop  = 1'b0;
        exmem_we  = 1'b0;
        memwb_nop = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        mw_inc    = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    pc_we    = 1'b1;
                    ifid_we  = 1'b1;
                    exmem_we = 1'b1;
                    if (bus.mem_req_i && !bus.mem_ready_i) begin
                        pc_we     = 1'b0;
                        ifid_we   = 1'b0;
                        exmem_we  = 1'b0;
                        memwb_nop = 1'b1;
                        mw_inc    = 1'b1;
                        state_d   = MEM_WAIT;
                    end else begin
                        if (bus.load_use_i) begin
                            pc_we     = 1'b0;
                            ifid_we   = 1'b0;
                            idex_nop  = 1'b1;
                            stall_inc = 1'b1;
                        end else if (bus.branch_taken_i) begin
                            ifid_fl   = 1'b1;
                            flush_inc = 1'b1;
                        end
                        if (!bus.start_i) begin
                            state_d = IDLE;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ready_i) begin
                        pc_we    = 1'b1;
                        ifid_we  = 1'b1;
                        exmem_we = 1'b1;
                        state_d  = RUN;
                    end else begin
                        memwb_nop = 1'b1;
                        mw_inc    = 1'b1;
                        // Hold the watchdog at the limit once reached.
                        if (wd_q == WD_W'(MEM_TIMEOUT)) begin
                            wd_d = wd_q;
                        end else begin
                            wd_d = wd_q + 1'b1;
                        end
                        if (wd_q >= WD_W'(MEM_TIMEOUT - 1)) begin
                            to_set = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM state, watchdog count and sticky timeout flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wd_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (to_set) begin
                to_q <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (bus.stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_inc),
        .cnt_o (bus.flush_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_memwait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (mw_inc),
        .cnt_o (bus.memwait_cnt_o)
    );

    assign bus.PCWrite_o      = pc_we;
    assign bus.IF_ID_Write_o  = ifid_we;
    assign bus.IF_ID_Flush_o  = ifid_fl;
    assign bus.ID_EX_NoOp_o   = idex_nop;
    assign bus.EX_MEM_Write_o = exmem_we;
    assign bus.MEM_WB_NoOp_o  = memwb_nop;
    assign bus.mem_wait_o     = !rst_i && (state_q == MEM_WAIT);
    assign bus.mem_timeout_o  = to_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (CNT_W=2, MEM_TIMEOUT=4).
// Control vector order: PCW, IFIDW, IFIDF, IDEXN, EXMEMW, MEMWBN.
module tb_pipeline_stall_ctrl;

    localparam int CW = 2;

    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_RUN   = 6'b110010;
    localparam logic [5:0] O_STALL = 6'b000110;
    localparam logic [5:0] O_FLUSH = 6'b111010;
    localparam logic [5:0] O_FRZ   = 6'b000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_stall_ctrl #(
        .CNT_W       (CW),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic logic [5:0] ctl();
        return {bus.PCWrite_o, bus.IF_ID_Write_o, bus.IF_ID_Flush_o,
                bus.ID_EX_NoOp_o, bus.EX_MEM_Write_o, bus.MEM_WB_NoOp_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic st, input logic lu, input logic br,
                       input logic rq, input logic rd);
        bus.start_i        = st;
        bus.load_use_i     = lu;
        bus.branch_taken_i = br;
        bus.mem_req_i      = rq;
        bus.mem_ready_i    = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [5:0] exp,
                           input logic wt);
        chk({tag, "_ctl"}, 32'(ctl()), 32'(exp));
        chk({tag, "_wait"}, 32'(bus.mem_wait_o), 32'(wt));
    endtask

    task automatic chk_cnt(input string tag, input int s, input int f,
                           input int m);
        chk({tag, "_stall"}, 32'(bus.stall_cnt_o), 32'(s));
        chk({tag, "_flush"}, 32'(bus.flush_cnt_o), 32'(f));
        chk({tag, "_mwait"}, 32'(bus.memwait_cnt_o), 32'(m));
    endtask

    initial begin
        drv(0, 0, 0, 0, 0);
        tick();
        tick();
        // reset held: idle outputs, cleared state
        chk_ctl("rst", O_IDLE, 0);
        chk_cnt("rst", 0, 0, 0);
        chk("rst_to", 32'(bus.mem_timeout_o), 0);

        // start: one IDLE cycle then RUN
        rst = 1'b0;
        drv(1, 0, 0, 0, 0);
        chk_ctl("idle1", O_IDLE, 0);
        tick();
        chk_ctl("run", O_RUN, 0);
        chk_cnt("run", 0, 0, 0);

        // single load-use stall
        drv(1, 1, 0, 0, 0);
        chk_ctl("lu", O_STALL, 0);
        tick();
        chk_cnt("lu", 1, 0, 0);

        // load-use beats branch
        drv(1, 1, 1, 0, 0);
        chk_ctl("lubr", O_STALL, 0);
        tick();
        chk_cnt("lubr", 2, 0, 0);

        // branch alone flushes
        drv(1, 0, 1, 0, 0);
        chk_ctl("br", O_FLUSH, 0);
        tick();
        chk_cnt("br", 2, 1, 0);

        // memory freeze 3 cycles, load-use held and ignored
        drv(1, 1, 0, 1, 0);
        chk_ctl("frz0", O_FRZ, 0);
        tick();
        chk_ctl("frz1", O_FRZ, 1);
        chk_cnt("frz1", 2, 1, 1);
        tick();
        chk_ctl("frz2", O_FRZ, 1);
        chk_cnt("frz2", 2, 1, 2);
        tick();
        drv(1, 1, 0, 1, 1);
        chk_ctl("rel", O_RUN, 1);
        chk_cnt("rel", 2, 1, 3);
        tick();
        // back in RUN; ready without req is ignored
        drv(1, 0, 0, 0, 1);
        chk_ctl("back", O_RUN, 0);
        chk_cnt("back", 2, 1, 3);

        // watchdog: ready held low, limit 4
        drv(1, 0, 0, 1, 0);
        tick();
        // start drop in MEM_WAIT has no effect
        drv(0, 0, 0, 1, 0);
        tick();
        tick();
        tick();
        chk("wd3_to", 32'(bus.mem_timeout_o), 0);
        chk_ctl("wd3", O_FRZ, 1);
        tick();
        chk("wd4_to", 32'(bus.mem_timeout_o), 1);
        chk_ctl("wd4", O_FRZ, 1);
        chk("mw_sat", 32'(bus.memwait_cnt_o), 3);
        drv(0, 0, 0, 1, 1);
        chk_ctl("wdrel", O_RUN, 1);
        tick();
        // RUN with start low: RUN outputs, then IDLE
        drv(0, 0, 0, 0, 0);
        chk_ctl("stop", O_RUN, 0);
        chk("sticky1", 32'(bus.mem_timeout_o), 1);
        tick();
        chk_ctl("idle2", O_IDLE, 0);
        chk("sticky2", 32'(bus.mem_timeout_o), 1);
        drv(1, 0, 0, 0, 0);
        tick();

        // stall counter saturation
        drv(1, 1, 0, 0, 0);
        tick();
        chk("sat1", 32'(bus.stall_cnt_o), 3);
        for (int i = 0; i < 5; i++) tick();
        chk("sat6", 32'(bus.stall_cnt_o), 3);

        // reset in the middle of MEM_WAIT
        drv(1, 0, 0, 1, 0);
        tick();
        chk_ctl("mw", O_FRZ, 1);
        rst = 1'b1;
        #1;
        chk_ctl("rstmw", O_IDLE, 0);
        tick();
        chk_cnt("rstmw", 0, 0, 0);
        chk("rstmw_to", 32'(bus.mem_timeout_o), 0);
        rst = 1'b0;
        drv(1, 0, 0, 0, 0);
        chk_ctl("idle3", O_IDLE, 0);
        tick();
        chk_ctl("run3", O_RUN, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
